// File: rtl/board_stream_tx.sv
// Transmit side of the board link: captures a Game of Life board on start and
// streams it out byte by byte (LSB byte first), optionally behind a header byte.
module board_stream_tx #(
    parameter int         BOARD_BITS  = 256,
    parameter int         HEADER_EN   = 1,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BOARD_BITS-1:0]  board_in,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int NUM_BYTES = BOARD_BITS / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [BOARD_BITS-1:0] shadow;
    logic [IDX_W-1:0]      idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode straight from the registered state, so the first byte
    // appears one cycle after the start edge and holds while stalled.
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (HEADER_EN != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = HEADER_BYTE;
                if (tx_ready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = shadow[8*idx +: 8];
                if (tx_ready && (idx == LAST_IDX)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The frame counter advances on the final handshake so the new value is
    // already visible during the done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow      <= '0;
            idx         <= '0;
            frame_count <= '0;
        end else if ((state == IDLE) && start) begin
            shadow <= board_in;
            idx    <= '0;
        end else if ((state == DATA) && tx_ready) begin
            if (idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end else begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_stream_tx.sv
// Randomized bench for board_stream_tx: three instances (default, no header,
// 2-bit frame counter) checked against a byte-queue model of each frame.
module tb_board_stream_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   start_v;
    logic [255:0] board_in;
    logic         tx_ready;

    logic         va, vb, vc, ba, bb, bc, dna, dnb, dnc;
    logic [7:0]   da, db, dc;
    logic [15:0]  fc_a, fc_b;
    logic [1:0]   fc_c;

    always #5 clk = ~clk;

    board_stream_tx dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .board_in(board_in),
        .tx_valid(va), .tx_ready(tx_ready), .tx_data(da), .busy(ba),
        .done(dna), .frame_count(fc_a)
    );

    board_stream_tx #(.HEADER_EN(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .board_in(board_in),
        .tx_valid(vb), .tx_ready(tx_ready), .tx_data(db), .busy(bb),
        .done(dnb), .frame_count(fc_b)
    );

    board_stream_tx #(.FRAME_CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .board_in(board_in),
        .tx_valid(vc), .tx_ready(tx_ready), .tx_data(dc), .busy(bc),
        .done(dnc), .frame_count(fc_c)
    );

    int         sel;
    logic       o_valid, o_busy, o_done;
    logic [7:0] o_data;
    logic [15:0] o_fc;

    always_comb begin
        case (sel)
            1:       begin o_valid = vb; o_busy = bb; o_done = dnb; o_data = db; o_fc = fc_b; end
            2:       begin o_valid = vc; o_busy = bc; o_done = dnc; o_data = dc; o_fc = {14'b0, fc_c}; end
            default: begin o_valid = va; o_busy = ba; o_done = dna; o_data = da; o_fc = fc_a; end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_board();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Sends one frame on instance s and compares every accepted byte with the
    // expected stream: optional header, then board bytes 0..31 in order.
    task automatic run_frame(input int s, input logic [255:0] board, input bit hdr,
                             input bit stall, input bit inject,
                             input logic [15:0] exp_fc, input string tag);
        logic [7:0] expq[$];
        int         got, cycles, last_hs, stall_left;
        bit         prev_hold, inj3, inj20, r;
        logic [7:0] prev_data;

        sel = s;
        if (hdr) expq.push_back(8'hA5);
        for (int i = 0; i < 32; i++) expq.push_back(board[8*i +: 8]);

        @(negedge clk);
        board_in = board;
        start_v  = 3'(1 << s);
        tx_ready = 1'b1;
        @(negedge clk);
        start_v  = '0;
        board_in = rand_board();

        got = 0; cycles = 0; last_hs = 0; stall_left = 0;
        prev_hold = 0; prev_data = 8'h00; inj3 = 0; inj20 = 0;
        while (!o_done && cycles < 2000) begin
            cycles++;
            start_v = '0;
            if (prev_hold) begin
                chk($sformatf("%s hold_valid", tag), 32'(o_valid), 32'd1);
                chk($sformatf("%s hold_data", tag), 32'(o_data), 32'(prev_data));
            end
            if (stall) begin
                if (stall_left > 0) begin
                    r = 1'b0; stall_left--;
                end else if ($urandom_range(0, 5) == 0) begin
                    r = 1'b0; stall_left = 4;
                end else begin
                    r = 1'($urandom_range(0, 1));
                end
            end else begin
                r = 1'b1;
            end
            tx_ready = r;
            if (o_valid && r) begin
                if (got < expq.size())
                    chk($sformatf("%s byte%0d", tag, got), 32'(o_data), 32'(expq[got]));
                else
                    chk($sformatf("%s extra_byte", tag), 32'(got), 32'(expq.size()));
                got++;
                last_hs = cycles;
            end
            prev_hold = o_valid && !r;
            prev_data = o_data;
            if (inject && got == 3 && !inj3) begin
                inj3 = 1; start_v = 3'(1 << s); board_in = rand_board();
            end
            if (inject && got == 20 && !inj20) begin
                inj20 = 1; start_v = 3'(1 << s); board_in = rand_board();
            end
            @(negedge clk);
        end
        start_v = '0;
        chk($sformatf("%s done_seen", tag), 32'(o_done), 32'd1);
        chk($sformatf("%s handshakes", tag), 32'(got), 32'(expq.size()));
        chk($sformatf("%s done_after_last", tag), 32'(cycles), 32'(last_hs));
        chk($sformatf("%s busy_in_done", tag), 32'(o_busy), 32'd0);
        chk($sformatf("%s valid_in_done", tag), 32'(o_valid), 32'd0);
        chk($sformatf("%s frame_count", tag), 32'(o_fc), 32'(exp_fc));
        if (!stall)
            chk($sformatf("%s frame_cycles", tag), 32'(cycles), 32'(expq.size()));
        if (inject) begin
            start_v  = 3'(1 << s);
            board_in = rand_board();
        end
        @(negedge clk);
        start_v = '0;
        chk($sformatf("%s idle_busy", tag), 32'(o_busy), 32'd0);
        chk($sformatf("%s idle_valid", tag), 32'(o_valid), 32'd0);
        chk($sformatf("%s single_done", tag), 32'(o_done), 32'd0);
    endtask

    initial begin
        logic [255:0] b;
        int           got, cyc;

        reset = 1'b1; start_v = '0; board_in = '0; tx_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        chk("rst tx_valid", 32'(va), 32'd0);
        chk("rst tx_data", 32'(da), 32'd0);
        chk("rst busy", 32'(ba), 32'd0);
        chk("rst done", 32'(dna), 32'd0);
        chk("rst frame_count", 32'(fc_a), 32'd0);
        reset = 1'b0;

        run_frame(0, 256'h1, 1, 0, 0, 16'd1, "one");
        b = '0; b[255] = 1'b1; b[128] = 1'b1;
        run_frame(0, b, 1, 0, 0, 16'd2, "bits255_128");
        run_frame(0, rand_board(), 1, 1, 0, 16'd3, "stall");
        run_frame(0, rand_board(), 1, 0, 1, 16'd4, "ignore_start");
        run_frame(1, {32{8'h3C}}, 0, 0, 0, 16'd1, "no_header");

        // Abort a frame with reset while byte 10 is on the bus.
        sel = 0;
        @(negedge clk);
        board_in = rand_board(); start_v = 3'b001; tx_ready = 1'b1;
        @(negedge clk);
        start_v = '0; got = 0; cyc = 0;
        while (got < 10 && cyc < 100) begin
            if (o_valid) got++;
            cyc++;
            @(negedge clk);
        end
        chk("abort reached_byte10", 32'(got), 32'd10);
        chk("abort busy_before", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort tx_valid", 32'(va), 32'd0);
        chk("abort busy", 32'(ba), 32'd0);
        chk("abort frame_count", 32'(fc_a), 32'd0);
        chk("abort tx_data", 32'(da), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort no_done", 32'(dna), 32'd0);
            @(negedge clk);
        end
        run_frame(0, rand_board(), 1, 1, 0, 16'd1, "after_abort");

        for (int i = 1; i <= 5; i++)
            run_frame(2, rand_board(), 1, 0, 0, 16'(i % 4), $sformatf("wrap%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_stream_tx.md
Name: board_stream_tx

Overview:
- Transmit side of the board link: captures one 256-bit Game of Life board (16x16, bit index = row*16 + col) on a start pulse.
- Serializes the board into a byte stream over a valid/ready handshake, optionally preceded by a header byte.
- Sits between the generation engine's board output and the byte-wide link transmitter (UART TX / host bridge).
- Keeps a count of completed frames for host-side sequencing.

Parameters:
- BOARD_BITS, 256, board width in bits; must be a multiple of 8.
- HEADER_EN, 1, 1 = send HEADER_BYTE before the board bytes; 0 = board bytes only.
- HEADER_BYTE, 8'hA5, frame sync value sent when HEADER_EN = 1.
- FRAME_CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to capture board_in and send one frame.
- board_in  input  BOARD_BITS  board to transmit; sampled only in the cycle start is accepted.
- tx_valid  output  1  tx_data holds a valid byte.
- tx_ready  input  1  downstream accepts the byte when tx_valid && tx_ready at a rising edge.
- tx_data  output  8  current byte.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the final byte of a frame is accepted.
- frame_count  output  FRAME_CNT_W  number of completed frames; wraps modulo 2^FRAME_CNT_W.

Behaviour:
- Clock and reset: clock is clk; reset is asynchronous and active-high.
- Reset values: state IDLE; tx_valid 0; tx_data 8'h00; busy 0; done 0; frame_count 0; shadow board register 0; byte index 0.
- NUM_BYTES = BOARD_BITS/8. Byte index width = clog2(NUM_BYTES), so 5 bits at the default.
- States:
  - IDLE: tx_valid = 0, busy = 0.
    - start = 1 at edge N: copy board_in to the shadow register, set busy = 1, clear the byte index.
    - Go to HDR if HEADER_EN = 1, else to DATA.
    - tx_valid rises in cycle N+1 with the first byte (1-cycle latency).
  - HDR: tx_data = HEADER_BYTE, tx_valid = 1.
    - On handshake, go to DATA with index 0.
  - DATA: tx_data = shadow[8*idx +: 8], tx_valid = 1. Byte 0 = bits 7:0 (row 0, cols 0-7), LSB-first.
    - On handshake with idx < NUM_BYTES-1: idx increments and the next byte is presented the following cycle.
    - No idle cycle between bytes when tx_ready is held high.
    - On handshake with idx = NUM_BYTES-1: go to FIN.
  - FIN: lasts exactly one cycle.
    - done = 1, busy = 0, tx_valid = 0.
    - frame_count increments, wrapping at 2^FRAME_CNT_W - 1 to 0.
    - Next state IDLE.
- Handshake rules:
  - While tx_valid = 1 and tx_ready = 0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a handshake except on reset.
  - tx_ready while tx_valid = 0 is ignored.
- start handling:
  - start outside IDLE is ignored and is not queued. This includes start in the FIN cycle.
  - board_in changes after capture do not affect the frame in progress.
- Frame length: HEADER_EN + NUM_BYTES handshakes, i.e. 33 at defaults. Minimum frame time with tx_ready = 1 is 1 + 33 + 1 cycles, from the start edge to the done cycle inclusive.
- Reset mid-frame:
  - Immediate abort: all outputs return to reset values, frame_count is cleared, and no done pulse occurs.
  - The next start after reset sends a complete frame from byte 0.

Test Plan:
- Reset, then start with board_in = 256'h1 and tx_ready = 1 -> bytes A5, 01, then 31 x 00 on consecutive cycles; done pulses once; frame_count = 1; busy low in the done cycle.
- board_in with bits 255 and 128 set (glider-free pattern) -> byte 16 = 8'h01, byte 31 = 8'h80, all other data bytes 00.
- tx_ready toggled at random, including 5-cycle low stalls -> every byte is held stable while stalled; the received stream matches board_in exactly; 33 handshakes total.
- start pulsed at bytes 3 and 20 of a frame and in the FIN cycle, with a different board_in each time -> all ignored; exactly one frame sent, carrying the original board; frame_count increments by 1.
- HEADER_EN = 0, board_in = {32{8'h3C}} -> exactly 32 bytes of 3C with no A5; done follows the 32nd handshake.
- Reset asserted at byte 10 -> tx_valid and busy drop immediately, frame_count = 0, no done; a following start sends a full 33-byte frame. Separately, FRAME_CNT_W = 2 with 5 frames -> frame_count sequence 1, 2, 3, 0, 1.
